// File: rtl/fp_align_sequencer_if.sv
// Operand/result handshake bundle for the FP adder alignment sequencer.
interface fp_align_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] big_mant;
  logic [23:0] small_mant;
  logic [2:0]  grs;
  logic [7:0]  exp_out;
  logic        sign_big;
  logic        sign_small;
  logic        big_is_a;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, big_mant, small_mant, grs, exp_out, sign_big, sign_small,
    input  big_is_a
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, big_mant, small_mant, grs, exp_out, sign_big, sign_small,
    output big_is_a
  );
endinterface

// File: rtl/fp_align_sequencer.sv
// Multi-cycle IEEE-754 single-precision operand alignment for the FP adder front end.
// Selects the larger operand and right-shifts the smaller mantissa with guard/round/sticky.
module fp_align_sequencer #(
  parameter int unsigned SHIFT_STEP = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  fp_align_sequencer_if.slave bus
);

  localparam logic [4:0] Step = 5'(SHIFT_STEP);

  typedef enum logic [1:0] {StIdle, StCompare, StShift, StDone} state_e;

  state_e      state;
  logic [31:0] a_q, b_q;
  logic [4:0]  cnt;
  logic [26:0] sh;
  logic        in_ready_q, out_valid_q;
  logic        big_is_a_q, sign_big_q, sign_small_q;
  logic [23:0] big_mant_q, small_mant_q;
  logic [2:0]  grs_q;
  logic [7:0]  exp_q;

  logic [7:0]  ea, eb, diff;
  logic [23:0] ma, mb;
  logic        a_big;
  logic [4:0]  n0;

  always_comb begin
    ea    = (a_q[30:23] == 8'd0) ? 8'd1 : a_q[30:23];
    eb    = (b_q[30:23] == 8'd0) ? 8'd1 : b_q[30:23];
    ma    = {|a_q[30:23], a_q[22:0]};
    mb    = {|b_q[30:23], b_q[22:0]};
    a_big = (ea > eb) || ((ea == eb) && (ma >= mb));
    diff  = a_big ? (ea - eb) : (eb - ea);
    n0    = (diff > 8'd27) ? 5'd27 : diff[4:0];
  end

  logic [4:0]  k;
  logic [26:0] mask, sh_next;

  // Bits falling off the bottom (including the old sticky) collapse into the new sticky bit.
  always_comb begin
    k          = (cnt < Step) ? cnt : Step;
    mask       = (27'd1 << k) - 27'd1;
    sh_next    = sh >> k;
    sh_next[0] = sh_next[0] | (|(sh & mask));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      cnt          <= '0;
      sh           <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      big_is_a_q   <= 1'b0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      big_mant_q   <= '0;
      small_mant_q <= '0;
      grs_q        <= '0;
      exp_q        <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            in_ready_q <= 1'b0;
            state      <= StCompare;
          end
        end
        StCompare: begin
          big_is_a_q   <= a_big;
          big_mant_q   <= a_big ? ma : mb;
          exp_q        <= a_big ? ea : eb;
          sign_big_q   <= a_big ? a_q[31] : b_q[31];
          sign_small_q <= a_big ? b_q[31] : a_q[31];
          sh           <= {(a_big ? mb : ma), 3'b000};
          cnt          <= n0;
          if (n0 == 5'd0) begin
            small_mant_q <= a_big ? mb : ma;
            grs_q        <= 3'b000;
            out_valid_q  <= 1'b1;
            state        <= StDone;
          end else begin
            state <= StShift;
          end
        end
        StShift: begin
          sh  <= sh_next;
          cnt <= cnt - k;
          if (cnt == k) begin
            small_mant_q <= sh_next[26:3];
            grs_q        <= sh_next[2:0];
            out_valid_q  <= 1'b1;
            state        <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.big_mant   = big_mant_q;
  assign bus.small_mant = small_mant_q;
  assign bus.grs        = grs_q;
  assign bus.exp_out    = exp_q;
  assign bus.sign_big   = sign_big_q;
  assign bus.sign_small = sign_small_q;
  assign bus.big_is_a   = big_is_a_q;

endmodule
